router_reg_chk: RTL and testbench
=================================

Name: router_reg_chk

Overview:
- Parametrised successor to the 1xN router's datapath register stage.
- Latches the header, forwards payload to the FIFOs, and holds one byte while the FIFO is full.
- Accumulates a configurable integrity check (XOR parity or additive checksum) and flags integrity errors.
- New in this generation: generic width and port count, checksum mode, payload-length check against the header length field.

Parameters:
- DATA_W, 8, data/header/check width in bits.
- ADDR_W, 2, header address field width; header = {len[DATA_W-1:ADDR_W], addr[ADDR_W-1:0]}.
- NUM_PORTS, 3, number of destination FIFOs; addr >= NUM_PORTS is invalid.
- CHK_MODE, 0, 0 = XOR parity, 1 = sum modulo 2^DATA_W.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pkt_valid  in  1  source driving header/payload; low on parity/check byte.
- fifo_full  in  1  selected destination FIFO full.
- rst_int_reg  in  1  FSM: clear low_pkt_valid.
- detect_add  in  1  FSM DECODE_ADDRESS state.
- ld_state  in  1  FSM LOAD_DATA state.
- laf_state  in  1  FSM LOAD_AFTER_FULL state.
- full_state  in  1  FSM FIFO_FULL_STATE.
- lfd_state  in  1  FSM LOAD_FIRST_DATA state.
- data_in  in  DATA_W  source byte.
- parity_done  out  1  check byte received and forwarded.
- low_pkt_valid  out  1  pkt_valid fell during LOAD_DATA.
- err  out  1  computed check != received check.
- len_err  out  1  payload count != header length.
- dout  out  DATA_W  byte to FIFO write port.

Behaviour:
Reset and clearing:
- On reset (any cycle, including mid-packet), all of the following go to 0: outputs, header reg, hold reg, int_chk, pkt_chk, len_cnt, and sticky flags.

Header latch:
- When detect_add && pkt_valid && addr < NUM_PORTS, latch hdr <= data_in.
- Invalid addr: hdr is unchanged.

Check and length initialisation:
- On detect_add: clear int_chk, pkt_chk, parity_done, err and len_err.
- On lfd_state: dout <= hdr; int_chk <= hdr; len_cnt <= hdr[DATA_W-1:ADDR_W].

Payload capture:
- Capture occurs when ld_state && pkt_valid && !full_state.
- Each capture updates int_chk <= int_chk ^ data_in (mode 0) or int_chk + data_in truncated to DATA_W (mode 1).
- If len_cnt == 0 at capture: set len_err (overflow, sticky) and leave len_cnt at 0.
- Otherwise: len_cnt <= len_cnt - 1.
- If !fifo_full: dout <= data_in.
- If fifo_full: hold <= data_in and dout holds its value.

Check byte:
- On ld_state && !pkt_valid: pkt_chk <= data_in and low_pkt_valid <= 1.
- In the same cycle, if !fifo_full: dout <= data_in and parity_done <= 1.
- If fifo_full: hold <= data_in.

Load after full:
- On laf_state: dout <= hold.
- If low_pkt_valid && !parity_done: parity_done <= 1.

Error flags:
- The cycle after parity_done rises: err <= (int_chk != pkt_chk); len_err <= len_err | (len_cnt != 0).
- err and len_err then hold until the next detect_add or reset.

low_pkt_valid:
- Cleared by rst_int_reg.
- If rst_int_reg coincides with a set condition, the clear wins.

Latency and timing rules:
- Every dout update appears one clock after the qualifying input cycle.
- full_state: no captures; dout, hold and int_chk are frozen.
- detect_add coinciding with rst_int_reg: both clears apply.
- Header length 0: the first payload capture sets len_err.

Test Plan:
1. Reset, then header 0x11 (len 4, addr 1), payloads 0x01..0x04, check byte 0x15, CHK_MODE=0 -> dout sequence 0x11,0x01,0x02,0x03,0x04,0x15; parity_done=1; err=0; len_err=0; low_pkt_valid clears on rst_int_reg.
2. Same packet with check byte 0xEA (~0x15) -> err=1 one cycle after parity_done; err clears on next detect_add.
3. CHK_MODE=1, same header/payloads, check byte 0x1B -> err=0; check byte 0x15 -> err=1.
4. Header 0x42 (len 16, addr 2), 15 random payloads, then 0xF0 with fifo_full=1, full_state for 3 cycles, then laf_state -> dout holds through full_state, then 0xF0 on laf; int_chk includes 0xF0 exactly once; len_err=0.
5. Header 0x11 (len 4) with 5 payloads -> len_err=1 at 5th capture; header 0x11 with 3 payloads -> len_err=1 after parity_done.
6. Header 0x13 (addr 3 >= NUM_PORTS) -> hdr not latched. Reset asserted mid-payload -> all outputs 0 next cycle; next good packet passes with err=0.

Source files
------------

// File: rtl/router_reg_chk.sv
// router_reg_chk: datapath register stage of the 1xN router.
// Latches the packet header, forwards header/payload/check bytes to the
// destination FIFO write port, parks one byte while the FIFO is full, and
// accumulates an integrity check (XOR parity or additive checksum) together
// with a payload-length count against the header length field.
module router_reg_chk #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int NUM_PORTS = 3,
  parameter int CHK_MODE  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              rst_int_reg,
  input  logic              detect_add,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              len_err,
  output logic [DATA_W-1:0] dout
);

  // Width of the header length field (upper bits of the header byte).
  localparam int          LEN_W   = DATA_W - ADDR_W;
  localparam int unsigned PORTS_U = NUM_PORTS;

  // Running integrity check: XOR parity or sum modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] chk_next(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] b
  );
    if (CHK_MODE == 1) begin
      return acc + b;
    end else begin
      return acc ^ b;
    end
  endfunction

  // Length counter step: saturate at zero, an overflow is flagged separately.
  function automatic logic [LEN_W-1:0] len_next(input logic [LEN_W-1:0] cnt);
    if (cnt == '0) begin
      return '0;
    end else begin
      return cnt - LEN_W'(1);
    end
  endfunction

  logic [DATA_W-1:0] hdr;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] int_chk;
  logic [DATA_W-1:0] pkt_chk;
  logic [LEN_W-1:0]  len_cnt;
  logic              parity_done_p1;

  logic addr_ok;
  logic hdr_load;
  logic capture;
  logic chk_byte;
  logic xfer;
  logic pd_rise;
  logic len_zero;

  // ---- stage 0: qualify the current input cycle ----
  assign addr_ok  = (32'(data_in[ADDR_W-1:0]) < PORTS_U);
  assign hdr_load = detect_add && pkt_valid && addr_ok;
  // A payload byte is taken only while loading data with the source active.
  assign capture  = ld_state && pkt_valid && !full_state;
  // Source dropping pkt_valid in LOAD_DATA marks the check byte.
  assign chk_byte = ld_state && !pkt_valid;
  // Any byte that is either written to the FIFO or parked in hold.
  assign xfer     = capture || (chk_byte && !full_state);
  // Error evaluation runs exactly once, the cycle after parity_done rises.
  assign pd_rise  = parity_done && !parity_done_p1;
  assign len_zero = (len_cnt == '0);

  // ---- stage 1: registered state ----

  // Header register: only headers that address an existing port are kept.
  always_ff @(posedge clock) begin
    if (reset) begin
      hdr <= '0;
    end else if (hdr_load) begin
      hdr <= data_in;
    end
  end

  // Hold register: parks the byte that arrived while the FIFO was full.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold <= '0;
    end else if (xfer && fifo_full) begin
      hold <= data_in;
    end
  end

  // FIFO write data: header, then payload/check bytes, then any parked byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= '0;
    end else if (!full_state) begin
      if (lfd_state) begin
        dout <= hdr;
      end else if (xfer && !fifo_full) begin
        dout <= data_in;
      end else if (laf_state) begin
        dout <= hold;
      end
    end
  end

  // Internal check: seeded with the header, folded with every captured payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      int_chk <= '0;
    end else if (detect_add) begin
      int_chk <= '0;
    end else if (lfd_state) begin
      int_chk <= hdr;
    end else if (capture) begin
      int_chk <= chk_next(int_chk, data_in);
    end
  end

  // Received check byte from the source.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_chk <= '0;
    end else if (detect_add) begin
      pkt_chk <= '0;
    end else if (chk_byte) begin
      pkt_chk <= data_in;
    end
  end

  // Remaining payload count, loaded from the header length field.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_cnt <= '0;
    end else if (lfd_state) begin
      len_cnt <= hdr[DATA_W-1:ADDR_W];
    end else if (capture) begin
      len_cnt <= len_next(len_cnt);
    end
  end

  // parity_done: check byte has reached the FIFO, directly or after a full stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_done <= 1'b0;
    end else if (detect_add) begin
      parity_done <= 1'b0;
    end else if (chk_byte && !full_state && !fifo_full) begin
      parity_done <= 1'b1;
    end else if (laf_state && low_pkt_valid && !parity_done) begin
      parity_done <= 1'b1;
    end
  end

  // Delayed parity_done for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_done_p1 <= 1'b0;
    end else begin
      parity_done_p1 <= parity_done;
    end
  end

  // low_pkt_valid: set on the check byte; an FSM clear wins over a set.
  always_ff @(posedge clock) begin
    if (reset) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (chk_byte) begin
      low_pkt_valid <= 1'b1;
    end
  end

  // ---- stage 2: integrity verdicts ----

  // Check error: compared once after parity_done, sticky until next header.
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (detect_add) begin
      err <= 1'b0;
    end else if (pd_rise) begin
      err <= (int_chk != pkt_chk);
    end
  end

  // Length error: overflow on capture, underflow at evaluation, sticky.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_err <= 1'b0;
    end else if (detect_add) begin
      len_err <= 1'b0;
    end else begin
      len_err <= len_err
               | (capture && len_zero)
               | (pd_rise && !len_zero);
    end
  end

endmodule

// File: tb/tb_router_reg_chk.sv
// Bench for router_reg_chk: two instances (XOR parity and additive checksum)
// share one stimulus stream; expectations come from a packet-level model.
module tb_router_reg_chk;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid, fifo_full, rst_int_reg, detect_add;
  logic       ld_state, laf_state, full_state, lfd_state;
  logic [7:0] data_in;

  logic       pd0, lpv0, err0, lerr0;
  logic [7:0] dout0;
  logic       pd1, lpv1, err1, lerr1;
  logic [7:0] dout1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Payload bytes of the packet currently being sent.
  logic [7:0] pl[$];
  // Header the DUT should hold (only valid-address headers are latched).
  logic [7:0] exp_hdr;
  // low_pkt_valid left set by the previous packet, to be cleared at detect.
  logic       pend_rst;

  router_reg_chk #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3), .CHK_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
    .data_in(data_in), .parity_done(pd0), .low_pkt_valid(lpv0), .err(err0),
    .len_err(lerr0), .dout(dout0)
  );

  router_reg_chk #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3), .CHK_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
    .data_in(data_in), .parity_done(pd1), .low_pkt_valid(lpv1), .err(err1),
    .len_err(lerr1), .dout(dout1)
  );

  always #5 clock = ~clock;

  // Reference check over header + payload queue: XOR of all bytes, or their
  // integer sum reduced modulo 256.
  function automatic logic [7:0] ref_chk(input int mode, input logic [7:0] h);
    int         sum;
    logic [7:0] x;
    sum = int'(h);
    x   = h;
    foreach (pl[i]) begin
      sum = sum + int'(pl[i]);
      x   = x ^ pl[i];
    end
    return (mode == 1) ? sum[7:0] : x;
  endfunction

  // One clock of FSM/source stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                       input logic fs, input logic ri, input logic pv, input logic ff,
                       input logic [7:0] d);
    detect_add  = da;
    lfd_state   = lfd;
    ld_state    = ld;
    laf_state   = laf;
    full_state  = fs;
    rst_int_reg = ri;
    pkt_valid   = pv;
    fifo_full   = ff;
    data_in     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    reset = 1'b0;
    exp_hdr  = 8'h00;
    pend_rst = 1'b0;
    n_cmp++;
    if ({pd0, lpv0, err0, lerr0, dout0} !== 12'h000 || {pd1, lpv1, err1, lerr1, dout1} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b%b%b%b/%h and %b%b%b%b/%h, want all 0",
               pd0, lpv0, err0, lerr0, dout0, pd1, lpv1, err1, lerr1, dout1);
    end
  endtask

  // Sends one packet: header h, payloads from pl, check byte chk.
  // full_idx: payload index that meets a full FIFO (-1 none), held for full_cyc cycles.
  // chk_full: check byte meets a full FIFO. clr_lpv: clear low_pkt_valid afterwards.
  task automatic send_pkt(input logic [7:0] h, input logic [7:0] chk, input int full_idx,
                          input int full_cyc, input bit chk_full, input bit clr_lpv);
    int         len;
    logic [7:0] last;
    logic       e_err0, e_err1, e_lerr;
    // header
    drive(1, 0, 0, 0, 0, pend_rst, 1, 0, h);
    if (h[1:0] != 2'd3) exp_hdr = h;
    pend_rst = 1'b0;
    n_cmp++;
    if ({pd0, err0, lerr0, lpv0} !== 4'b0 || {pd1, err1, lerr1, lpv1} !== 4'b0) begin
      n_fail++;
      $display("FAIL detect_clear: got pd/err/lerr/lpv %b%b%b%b and %b%b%b%b, want 0000",
               pd0, err0, lerr0, lpv0, pd1, err1, lerr1, lpv1);
    end
    // first data: header goes out
    drive(0, 1, 0, 0, 0, 0, 1, 0, 8'($urandom));
    n_cmp++;
    if (dout0 !== exp_hdr || dout1 !== exp_hdr) begin
      n_fail++;
      $display("FAIL lfd_dout: got %h/%h want %h", dout0, dout1, exp_hdr);
    end
    len  = int'(exp_hdr[7:2]);
    last = exp_hdr;
    // payload
    foreach (pl[i]) begin
      if (i == full_idx) begin
        drive(0, 0, 1, 0, 0, 0, 1, 1, pl[i]);
        n_cmp++;
        if (dout0 !== last || dout1 !== last) begin
          n_fail++;
          $display("FAIL full_hold_dout: idx %0d got %h/%h want %h", i, dout0, dout1, last);
        end
        for (int c = 0; c < full_cyc; c++) begin
          drive(0, 0, 0, 0, 1, 0, 1, 1, 8'($urandom));
          n_cmp++;
          if (dout0 !== last || dout1 !== last) begin
            n_fail++;
            $display("FAIL full_state_dout: cyc %0d got %h/%h want %h", c, dout0, dout1, last);
          end
        end
        drive(0, 0, 0, 1, 0, 0, 1, 0, 8'($urandom));
        n_cmp++;
        if (dout0 !== pl[i] || dout1 !== pl[i] || pd0 !== 1'b0) begin
          n_fail++;
          $display("FAIL laf_dout: got %h/%h pd %b want %h pd 0", dout0, dout1, pd0, pl[i]);
        end
      end else begin
        drive(0, 0, 1, 0, 0, 0, 1, 0, pl[i]);
        n_cmp++;
        if (dout0 !== pl[i] || dout1 !== pl[i]) begin
          n_fail++;
          $display("FAIL payload_dout: idx %0d got %h/%h want %h", i, dout0, dout1, pl[i]);
        end
      end
      n_cmp++;
      if (lerr0 !== (i + 1 > len) || lerr1 !== (i + 1 > len)) begin
        n_fail++;
        $display("FAIL overflow_len_err: idx %0d len %0d got %b/%b want %b", i, len, lerr0, lerr1, (i + 1 > len));
      end
      last = pl[i];
    end
    // check byte
    if (chk_full) begin
      drive(0, 0, 1, 0, 0, 0, 0, 1, chk);
      n_cmp++;
      if (dout0 !== last || pd0 !== 1'b0 || pd1 !== 1'b0 || lpv0 !== 1'b1 || lpv1 !== 1'b1) begin
        n_fail++;
        $display("FAIL chk_full: got dout %h pd %b%b lpv %b%b want dout %h pd 00 lpv 11",
                 dout0, pd0, pd1, lpv0, lpv1, last);
      end
      drive(0, 0, 0, 0, 1, 0, 0, 1, 8'($urandom));
      n_cmp++;
      if (dout0 !== last || dout1 !== last || pd0 !== 1'b0) begin
        n_fail++;
        $display("FAIL chk_full_state: got dout %h/%h pd %b want %h pd 0", dout0, dout1, pd0, last);
      end
      drive(0, 0, 0, 1, 0, 0, 0, 0, 8'($urandom));
    end else begin
      drive(0, 0, 1, 0, 0, 0, 0, 0, chk);
    end
    n_cmp++;
    if (dout0 !== chk || dout1 !== chk || {pd0, pd1, lpv0, lpv1} !== 4'b1111 || err0 !== 1'b0 || err1 !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_done: got dout %h/%h pd %b%b lpv %b%b err %b%b want %h pd 11 lpv 11 err 00",
               dout0, dout1, pd0, pd1, lpv0, lpv1, err0, err1, chk);
    end
    // evaluation cycle
    e_err0 = (ref_chk(0, exp_hdr) != chk);
    e_err1 = (ref_chk(1, exp_hdr) != chk);
    e_lerr = (pl.size() != len);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'($urandom));
    n_cmp++;
    if (err0 !== e_err0 || err1 !== e_err1) begin
      n_fail++;
      $display("FAIL err_eval: got %b/%b want %b/%b", err0, err1, e_err0, e_err1);
    end
    n_cmp++;
    if (lerr0 !== e_lerr || lerr1 !== e_lerr) begin
      n_fail++;
      $display("FAIL len_err_eval: got %b/%b want %b (n %0d len %0d)", lerr0, lerr1, e_lerr, pl.size(), len);
    end
    if (clr_lpv) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0, 8'($urandom));
      n_cmp++;
      if (lpv0 !== 1'b0 || lpv1 !== 1'b0 || err0 !== e_err0 || pd0 !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_int_clear: got lpv %b%b err %b pd %b want lpv 00 err %b pd 1",
                 lpv0, lpv1, err0, pd0, e_err0);
      end
    end else begin
      pend_rst = 1'b1;
    end
  endtask

  // Known packet under both check modes, good and bad check bytes.
  task automatic test_basic();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(8'h11, 8'h15, -1, 0, 1'b0, 1'b1);
    send_pkt(8'h11, 8'hEA, -1, 0, 1'b0, 1'b0);
    send_pkt(8'h11, 8'h1B, -1, 0, 1'b0, 1'b1);
  endtask

  // Long packet with a full FIFO on the last payload, then on the check byte.
  task automatic test_full();
    pl.delete();
    for (int i = 0; i < 15; i++) pl.push_back(8'($urandom));
    pl.push_back(8'hF0);
    send_pkt(8'h42, ref_chk(0, 8'h42), 15, 3, 1'b0, 1'b1);
    send_pkt(8'h42, ref_chk(1, 8'h42), 4, 1, 1'b1, 1'b1);
  endtask

  // Length overflow, underflow and zero-length header.
  task automatic test_len();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pkt(8'h11, ref_chk(0, 8'h11), -1, 0, 1'b0, 1'b1);
    pl = '{8'h01, 8'h02, 8'h03};
    send_pkt(8'h11, ref_chk(0, 8'h11), -1, 0, 1'b0, 1'b1);
    pl = '{8'hAA};
    send_pkt(8'h01, ref_chk(0, 8'h01), -1, 0, 1'b0, 1'b1);
  endtask

  // Invalid address, reset mid-payload, recovery.
  task automatic test_bad_addr_reset();
    logic [7:0] keep;
    keep = exp_hdr;
    pl.delete();
    for (int i = 0; i < int'(keep[7:2]); i++) pl.push_back(8'($urandom));
    send_pkt(8'h13, ref_chk(0, keep), -1, 0, 1'b0, 1'b1);
    n_cmp++;
    if (exp_hdr !== keep) begin
      n_fail++;
      $display("FAIL bad_addr_model: got %h want %h", exp_hdr, keep);
    end
    drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h21);
    drive(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h5A);
    drive(0, 0, 1, 0, 0, 0, 1, 1, 8'h6B);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 8'h3C);
    reset = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h77);
    reset = 1'b0;
    exp_hdr  = 8'h00;
    pend_rst = 1'b0;
    n_cmp++;
    if ({pd0, lpv0, err0, lerr0, dout0} !== 12'h000 || {pd1, lpv1, err1, lerr1, dout1} !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_reset: got %b%b%b%b/%h and %b%b%b%b/%h, want all 0",
               pd0, lpv0, err0, lerr0, dout0, pd1, lpv1, err1, lerr1, dout1);
    end
    // header register was cleared: an invalid header now exposes 0x00
    pl.delete();
    send_pkt(8'h13, ref_chk(0, 8'h00), -1, 0, 1'b0, 1'b1);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(8'h11, 8'h15, -1, 0, 1'b0, 1'b1);
  endtask

  // Random back-to-back packets with random stalls, lengths and check bytes.
  task automatic test_random();
    logic [7:0] h, eff, chk;
    int         len, n, fidx;
    for (int k = 0; k < 24; k++) begin
      h   = {6'($urandom_range(0, 10)), 2'($urandom_range(0, 3))};
      eff = (h[1:0] != 2'd3) ? h : exp_hdr;
      len = int'(eff[7:2]);
      n   = len + int'($urandom_range(0, 2)) - 1;
      if (n < 0) n = 0;
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      fidx = -1;
      if (n > 0 && $urandom_range(0, 1) == 1) fidx = int'($urandom_range(0, n - 1));
      case ($urandom_range(0, 2))
        0:       chk = ref_chk(0, eff);
        1:       chk = ref_chk(1, eff);
        default: chk = 8'($urandom);
      endcase
      send_pkt(h, chk, fidx, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset       = 1'b1;
    pkt_valid   = 1'b0;
    fifo_full   = 1'b0;
    rst_int_reg = 1'b0;
    detect_add  = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    lfd_state   = 1'b0;
    data_in     = 8'h00;
    exp_hdr     = 8'h00;
    pend_rst    = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_len();
    test_bad_addr_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
